swervolf_wb_cmd_master: RTL
===========================

# swervolf_wb_cmd_master

Wishbone classic initiator that turns a valid/ready command stream into single Wishbone read or write cycles and returns one response per command. It sits between a command source (debug bridge, boot sequencer) and the SoC Wishbone interconnect, driving peripherals such as the system controller. A per-transaction timeout guarantees a response even when no slave acknowledges.

## Interface
- AW, 32: Wishbone/command address width.
- TIMEOUT, 255: maximum cycles o_wb_cyc stays high waiting for ack (≥2).
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  command accepted when valid & ready.
- i_cmd_we  in  1  1 = write, 0 = read.
- i_cmd_adr  in  AW  byte address.
- i_cmd_dat  in  32  write data.
- i_cmd_sel  in  4  byte enables.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  response consumed when valid & ready.
- o_rsp_dat  out  32  read data (0 for writes and timeouts).
- o_rsp_err  out  1  1 = transaction timed out.
- o_wb_adr  out  AW, o_wb_dat  out  32, o_wb_sel  out  4, o_wb_we  out  1, o_wb_cyc  out  1, o_wb_stb  out  1: Wishbone master outputs.
- i_wb_rdt  in  32, i_wb_ack  in  1: Wishbone slave returns.

## Operation
- States: IDLE, BUS, RSP. Reset → IDLE.
- IDLE: o_cmd_ready=1. On i_cmd_valid: register adr/dat/sel/we onto o_wb_*, set o_wb_cyc=o_wb_stb=1, clear timeout counter, → BUS.
- BUS: o_cmd_ready=0; o_wb_* held stable. Counter increments each cycle without ack.
  - i_wb_ack sampled: cyc/stb←0; o_rsp_dat←i_wb_rdt if read, else 0; o_rsp_err←0; → RSP.
  - No ack and counter==TIMEOUT-1: cyc/stb←0; o_rsp_dat←0; o_rsp_err←1; → RSP.
  - Ack in the expiry cycle: ack wins, err=0.
- RSP: o_rsp_valid=1, o_rsp_dat/err stable until i_rsp_ready; then o_rsp_valid←0, → IDLE. New command not accepted in RSP (no overlap).
- i_wb_ack in IDLE or RSP (stale/late ack) ignored, no state change.
- o_wb_adr/dat/sel/we keep last values after the cycle ends; only cyc/stb drop.
- Counter width: clog2(TIMEOUT)+1 bits; no wrap possible since it is cleared on entry to BUS.

## Timing
- Reset values: o_wb_cyc=o_wb_stb=o_wb_we=0, o_wb_adr=0, o_wb_dat=0, o_wb_sel=0, o_rsp_valid=0, o_rsp_dat=0, o_rsp_err=0; o_cmd_ready=0 while i_rst high, 1 in first cycle after.
- Command accepted at edge E0 → cyc/stb high from E0.
- Ack sampled high at edge Ea → cyc/stb low and o_rsp_valid high from Ea (cyc high exactly through the ack cycle, no extra cycle, so slaves acking on cyc without stb never double-ack).
- Slave acking one cycle after cyc rises: cyc high 2 cycles; rsp_valid 2 cycles after accept.
- Timeout: cyc/stb high exactly TIMEOUT cycles, then rsp_valid with err=1.
- Back-to-back: response taken at edge Er → o_cmd_ready=1 from Er; minimum command spacing 3 cycles with 1-cycle-ack slave and always-ready sink.
- Reset mid-BUS or mid-RSP: next edge all outputs at reset values, pending command/response discarded.

## Test plan
- Write 0x0000_00A5 sel=0001 to adr 0x10, slave acks 1 cycle after cyc → o_wb_dat=0x000000A5, we=1, cyc high 2 cycles, rsp err=0 dat=0.
- Read adr 0x00, slave acks returning 0x8001_0203 → o_rsp_dat=0x80010203, err=0, rsp_valid 2 cycles after accept.
- Read with no ack, TIMEOUT=8 → cyc high exactly 8 cycles, rsp err=1 dat=0; later ack pulse in RSP ignored.
- Ack arriving in cycle TIMEOUT of a read returning 0x1234 → err=0, dat=0x1234.
- Hold i_rsp_ready=0 for 5 cycles with i_cmd_valid high → rsp stable, o_cmd_ready=0, no second cyc until response taken.
- Assert i_rst while cyc high → cyc/stb/rsp_valid 0 next cycle, o_cmd_ready 1 after release, fresh command completes normally.

Source files
------------

// File: rtl/swervolf_wb_cmd_master_if.sv
// Command/response stream plus Wishbone classic master bus bundled for the
// command master. "master" is the view of the block that drives the bus.
interface swervolf_wb_cmd_master_if #(
    parameter int AW = 32
);
    // command stream
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic          i_cmd_we;
    logic [AW-1:0] i_cmd_adr;
    logic [31:0]   i_cmd_dat;
    logic [3:0]    i_cmd_sel;
    // response stream
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [31:0]   o_rsp_dat;
    logic          o_rsp_err;
    // wishbone
    logic [AW-1:0] o_wb_adr;
    logic [31:0]   o_wb_dat;
    logic [3:0]    o_wb_sel;
    logic          o_wb_we;
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic [31:0]   i_wb_rdt;
    logic          i_wb_ack;

    modport master (
        input  i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_dat, i_cmd_sel,
        input  i_rsp_ready, i_wb_rdt, i_wb_ack,
        output o_cmd_ready, o_rsp_valid, o_rsp_dat, o_rsp_err,
        output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb
    );

    modport slave (
        output i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_dat, i_cmd_sel,
        output i_rsp_ready, i_wb_rdt, i_wb_ack,
        input  o_cmd_ready, o_rsp_valid, o_rsp_dat, o_rsp_err,
        input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb
    );
endinterface

// File: rtl/swervolf_wb_cmd_master.sv
// Wishbone classic initiator: one command in, one single-beat bus cycle,
// one response out. A timeout guarantees a response if no slave acks.
module swervolf_wb_cmd_master #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input logic                       i_clk,
    input logic                       i_rst,
    swervolf_wb_cmd_master_if.master  bus
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic [31:0]   rsp_dat_q, rsp_dat_d;
    logic          rsp_err_q, rsp_err_d;

    // Next-state logic; bus address/data only change on command accept so
    // they keep their last values after cyc drops.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.i_cmd_valid) begin
                    adr_d   = bus.i_cmd_adr;
                    dat_d   = bus.i_cmd_dat;
                    sel_d   = bus.i_cmd_sel;
                    we_d    = bus.i_cmd_we;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // ack has priority over expiry in the same cycle
                if (bus.i_wb_ack) begin
                    rsp_dat_d = we_q ? 32'h0 : bus.i_wb_rdt;
                    rsp_err_d = 1'b0;
                    state_d   = RSP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_dat_d = 32'h0;
                    rsp_err_d = 1'b1;
                    state_d   = RSP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RSP: begin
                if (bus.i_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any pending transaction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // cyc/stb and rsp_valid are pure state decodes, so cyc falls on the
    // same edge that samples ack and never lingers an extra cycle.
    always_comb begin
        bus.o_cmd_ready = (state_q == IDLE) && !i_rst;
        bus.o_wb_cyc    = (state_q == BUS);
        bus.o_wb_stb    = (state_q == BUS);
        bus.o_rsp_valid = (state_q == RSP);
        bus.o_wb_adr    = adr_q;
        bus.o_wb_dat    = dat_q;
        bus.o_wb_sel    = sel_q;
        bus.o_wb_we     = we_q;
        bus.o_rsp_dat   = rsp_dat_q;
        bus.o_rsp_err   = rsp_err_q;
    end
endmodule
